// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response bundle between the control sequencer
// (master: drives MAR/MDR and read/write strobes) and the memory access unit
// (slave: returns read data, busy, done and addr_err).
//   mar_addr  [31:0]  word address from MAR
//   mdr_data  [DW-1:0] write data from MDR
//   read/write        request strobes, sampled only while busy=0
//   mdata_out [DW-1:0] last completed read data
//   busy/done/addr_err status back to the control unit
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           mar_addr;
  logic [DATA_WIDTH-1:0] mdr_data;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] mdata_out;
  logic                  busy;
  logic                  done;
  logic                  addr_err;

  modport master (
    output mar_addr, mdr_data, read, write,
    input  mdata_out, busy, done, addr_err
  );

  modport slave (
    input  mar_addr, mdr_data, read, write,
    output mdata_out, busy, done, addr_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage behind the MAR/MDR pair. Accepts one read or
// write request at a time, inserts WAIT_STATES wait cycles, performs the access
// on an internal DEPTH x DATA_WIDTH memory and pulses done for one cycle.
// Out-of-range addresses and read+write requests are sequenced with the same
// timing but perform no access and raise addr_err with done.
//   clock  system clock (rising edge)
//   clear  synchronous active-high reset (memory contents kept)
//   bus    mem_access_unit_if slave modport
//
// state | meaning
// IDLE  | waiting for a request, busy=0
// WAIT  | request captured, counting down wait states
// RESP  | access committed, done=1 for one cycle
module mem_access_unit #(
  parameter int DEPTH       = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input logic              clock,
  input logic              clear,
  mem_access_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  accept, commit;

  logic [AW-1:0]         cap_idx;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_write;
  logic                  cap_err;

  logic                  req_err;
  logic [AW-1:0]         c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  c_write;
  logic                  c_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mdata_q;

  assign req_err = (bus.mar_addr[31:AW] != '0) || (bus.read && bus.write);

  // With zero wait states the commit lands on the accept edge, before the
  // capture registers are loaded, so the live request is used in IDLE.
  always_comb begin
    if (state == IDLE) begin
      c_idx   = bus.mar_addr[AW-1:0];
      c_data  = bus.mdr_data;
      c_write = bus.write && !bus.read;
      c_err   = req_err;
    end else begin
      c_idx   = cap_idx;
      c_data  = cap_data;
      c_write = cap_write;
      c_err   = cap_err;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read || bus.write) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      cnt     <= '0;
      mdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (commit && !c_write && !c_err)
        mdata_q <= mem[c_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!clear && accept) begin
      cap_idx   <= bus.mar_addr[AW-1:0];
      cap_data  <= bus.mdr_data;
      cap_write <= bus.write && !bus.read;
      cap_err   <= req_err;
    end
  end

  // Memory array is deliberately outside the reset; clear only blocks a commit.
  always_ff @(posedge clock) begin
    if (!clear && commit && c_write && !c_err)
      mem[c_idx] <= c_data;
  end

  assign bus.mdata_out = mdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == RESP);
  assign bus.addr_err  = (state == RESP) && cap_err;
endmodule
